// File: rtl/wb_ic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_ic_pkg
// Purpose  : Shared types and constants for the wishbone shared-bus
//            interconnect: FSM state encoding, slave index codes, default
//            slave address windows and the address-window match helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package wb_ic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_ERR      = 2'd2,
        ST_WAITDROP = 2'd3
    } ic_state_t;

    localparam logic [1:0] SLV_ROM  = 2'd0;
    localparam logic [1:0] SLV_RAM  = 2'd1;
    localparam logic [1:0] SLV_UART = 2'd2;
    localparam logic [1:0] SLV_NONE = 2'd3;

    localparam logic [31:0] ROM_BASE_DEF  = 32'h0000_0000;
    localparam logic [31:0] ROM_MASK_DEF  = 32'hFFFF_F800;
    localparam logic [31:0] RAM_BASE_DEF  = 32'h1000_0000;
    localparam logic [31:0] RAM_MASK_DEF  = 32'hFFFF_0000;
    localparam logic [31:0] UART_BASE_DEF = 32'h8000_0000;
    localparam logic [31:0] UART_MASK_DEF = 32'hFFFF_FFE0;

    function automatic logic addr_hit(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
        return (adr & mask) == base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_ic_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_ic_arbiter
// Purpose  : Two-way round-robin grant register. A grant is taken when no
//            grant is held and at least one request is present; on a tie the
//            master that did not win last time is chosen.
// Ports    : inclk0        clock
//            areset        synchronous active-high reset
//            req[1:0]      request per master (only presented while idle)
//            release_grant drop the current grant
//            grant_valid   a grant is held
//            grant_idx     index of the granted master
// Revision : 1.0 - initial release
// ============================================================================
module wb_ic_arbiter (
    input  logic       inclk0,
    input  logic       areset,
    input  logic [1:0] req,
    input  logic       release_grant,
    output logic       grant_valid,
    output logic       grant_idx
);
    import wb_ic_pkg::*;

    logic last_grant;
    logic pick;

    always_comb begin
        if (req == 2'b11) pick = ~last_grant;
        else              pick = req[1];
    end

    always_ff @(posedge inclk0) begin
        if (areset) begin
            grant_valid <= 1'b0;
            grant_idx   <= 1'b0;
            // Starting at 1 makes master 0 win the first tie.
            last_grant  <= 1'b1;
        end else if (release_grant) begin
            grant_valid <= 1'b0;
        end else if (!grant_valid && (req != 2'b00)) begin
            grant_valid <= 1'b1;
            grant_idx   <= pick;
            last_grant  <= pick;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_shared_bus_ic.sv
`default_nettype none
// ============================================================================
// Module   : wb_shared_bus_ic
// Purpose  : Wishbone shared-bus interconnect: two masters (ibus, dbus),
//            three slaves (boot ROM, RAM, UART). Arbitrates, decodes the
//            granted master's address every cycle, routes the cycle to the
//            decoded slave with no added latency, and errors unmapped
//            addresses and slaves that stall for TIMEOUT cycles.
// Ports    : inclk0, areset       clock / synchronous active-high reset
//            mN_*  (N=0,1)        master-side wishbone ports
//            sK_*  (K=0,1,2)      slave-side wishbone ports
// Revision : 1.0 - initial release
// ============================================================================
module wb_shared_bus_ic
    import wb_ic_pkg::*;
#(
    parameter logic [31:0] S0_BASE = ROM_BASE_DEF,
    parameter logic [31:0] S0_MASK = ROM_MASK_DEF,
    parameter logic [31:0] S1_BASE = RAM_BASE_DEF,
    parameter logic [31:0] S1_MASK = RAM_MASK_DEF,
    parameter logic [31:0] S2_BASE = UART_BASE_DEF,
    parameter logic [31:0] S2_MASK = UART_MASK_DEF,
    parameter int          TIMEOUT = 255
) (
    input  logic        inclk0,
    input  logic        areset,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] s0_adr_o,
    output logic [31:0] s0_dat_o,
    input  logic [31:0] s0_dat_i,
    output logic        s0_we_o,
    output logic [3:0]  s0_sel_o,
    output logic        s0_stb_o,
    output logic        s0_cyc_o,
    input  logic        s0_ack_i,
    output logic [31:0] s1_adr_o,
    output logic [31:0] s1_dat_o,
    input  logic [31:0] s1_dat_i,
    output logic        s1_we_o,
    output logic [3:0]  s1_sel_o,
    output logic        s1_stb_o,
    output logic        s1_cyc_o,
    input  logic        s1_ack_i,
    output logic [31:0] s2_adr_o,
    output logic [31:0] s2_dat_o,
    input  logic [31:0] s2_dat_i,
    output logic        s2_we_o,
    output logic [3:0]  s2_sel_o,
    output logic        s2_stb_o,
    output logic        s2_cyc_o,
    input  logic        s2_ack_i
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    // Master and slave ports gathered into arrays so routing is indexable.
    logic [31:0] m_adr [2];
    logic [31:0] m_wdat[2];
    logic        m_we  [2];
    logic [3:0]  m_sel [2];
    logic        m_stb [2];
    logic        m_cyc [2];
    // Entry 3 stands for "no slave" and reads back as idle.
    logic [31:0] s_rdat[4];
    logic        s_ack [4];

    assign m_adr  = '{m0_adr_i, m1_adr_i};
    assign m_wdat = '{m0_dat_i, m1_dat_i};
    assign m_we   = '{m0_we_i,  m1_we_i};
    assign m_sel  = '{m0_sel_i, m1_sel_i};
    assign m_stb  = '{m0_stb_i, m1_stb_i};
    assign m_cyc  = '{m0_cyc_i, m1_cyc_i};
    assign s_rdat = '{s0_dat_i, s1_dat_i, s2_dat_i, 32'h0};
    assign s_ack  = '{s0_ack_i, s1_ack_i, s2_ack_i, 1'b0};

    ic_state_t   state;
    logic [15:0] tcnt;
    logic        grant_valid;
    logic        grant_idx;
    logic [1:0]  req;
    logic        release_grant;

    logic        cyc_g;
    logic        stb_g;
    logic [31:0] adr_g;
    logic [1:0]  slv;
    logic        hit;
    logic        busy;
    logic        active;
    logic        slave_ack;

    assign cyc_g = m_cyc[grant_idx];
    assign stb_g = m_stb[grant_idx] && cyc_g;
    assign adr_g = m_adr[grant_idx];

    // Checked from the highest index down so the lowest index wins overlaps.
    always_comb begin
        slv = SLV_NONE;
        if (addr_hit(adr_g, S2_BASE, S2_MASK)) slv = SLV_UART;
        if (addr_hit(adr_g, S1_BASE, S1_MASK)) slv = SLV_RAM;
        if (addr_hit(adr_g, S0_BASE, S0_MASK)) slv = SLV_ROM;
    end

    assign hit       = (slv != SLV_NONE);
    assign busy      = (state == ST_BUSY) && grant_valid;
    assign active    = busy && stb_g && hit;
    assign slave_ack = active && s_ack[slv];

    // Requests are only offered to the arbiter while idle.
    assign req = (state == ST_IDLE) ? {m_cyc[1] && m_stb[1], m_cyc[0] && m_stb[0]}
                                    : 2'b00;
    assign release_grant = ((state == ST_BUSY) || (state == ST_WAITDROP)) && !cyc_g;

    wb_ic_arbiter u_arb (
        .inclk0        (inclk0),
        .areset        (areset),
        .req           (req),
        .release_grant (release_grant),
        .grant_valid   (grant_valid),
        .grant_idx     (grant_idx)
    );

    always_ff @(posedge inclk0) begin
        if (areset) begin
            state <= ST_IDLE;
            tcnt  <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tcnt <= 16'd0;
                    if (req != 2'b00) state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (!cyc_g) begin
                        state <= ST_IDLE;
                        tcnt  <= 16'd0;
                    end else if (stb_g && !hit) begin
                        state <= ST_ERR;
                        tcnt  <= 16'd0;
                    end else if (active) begin
                        // An ack in the expiry cycle still completes the access.
                        if (s_ack[slv]) begin
                            tcnt <= 16'd0;
                        end else if (tcnt == TO_LAST) begin
                            state <= ST_ERR;
                            tcnt  <= 16'd0;
                        end else begin
                            tcnt <= tcnt + 16'd1;
                        end
                    end
                end
                ST_ERR: begin
                    state <= ST_WAITDROP;
                end
                ST_WAITDROP: begin
                    if (!cyc_g) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Slave-side routing: only the decoded slave sees the granted master.
    logic [31:0] s_adr [3];
    logic [31:0] s_wdat[3];
    logic        s_we  [3];
    logic [3:0]  s_sel [3];
    logic        s_stb [3];
    logic        s_cyc [3];

    generate
        for (genvar k = 0; k < 3; k++) begin : g_slave
            logic pick;
            assign pick      = busy && cyc_g && (slv == 2'(k));
            assign s_cyc[k]  = pick;
            assign s_stb[k]  = pick && m_stb[grant_idx];
            assign s_adr[k]  = pick ? adr_g : 32'h0;
            assign s_wdat[k] = pick ? m_wdat[grant_idx] : 32'h0;
            assign s_we[k]   = pick && m_we[grant_idx];
            assign s_sel[k]  = pick ? m_sel[grant_idx] : 4'h0;
        end
    endgenerate

    // Master-side return path.
    logic [31:0] rdat_out[2];
    logic        ack_out [2];
    logic        err_out [2];

    generate
        for (genvar n = 0; n < 2; n++) begin : g_master
            logic own;
            assign own         = grant_valid && (grant_idx == 1'(n));
            assign ack_out[n]  = own && slave_ack;
            assign err_out[n]  = own && (state == ST_ERR);
            assign rdat_out[n] = (own && busy && hit) ? s_rdat[slv] : 32'h0;
        end
    endgenerate

    assign m0_dat_o = rdat_out[0];
    assign m0_ack_o = ack_out[0];
    assign m0_err_o = err_out[0];
    assign m1_dat_o = rdat_out[1];
    assign m1_ack_o = ack_out[1];
    assign m1_err_o = err_out[1];

    assign s0_adr_o = s_adr[0];
    assign s0_dat_o = s_wdat[0];
    assign s0_we_o  = s_we[0];
    assign s0_sel_o = s_sel[0];
    assign s0_stb_o = s_stb[0];
    assign s0_cyc_o = s_cyc[0];
    assign s1_adr_o = s_adr[1];
    assign s1_dat_o = s_wdat[1];
    assign s1_we_o  = s_we[1];
    assign s1_sel_o = s_sel[1];
    assign s1_stb_o = s_stb[1];
    assign s1_cyc_o = s_cyc[1];
    assign s2_adr_o = s_adr[2];
    assign s2_dat_o = s_wdat[2];
    assign s2_we_o  = s_we[2];
    assign s2_sel_o = s_sel[2];
    assign s2_stb_o = s_stb[2];
    assign s2_cyc_o = s_cyc[2];

endmodule
`default_nettype wire

// File: tb/tb_wb_shared_bus_ic.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_shared_bus_ic
// Purpose  : Self-checking bench for wb_shared_bus_ic: a table of single
//            transactions plus hand-written tie, timeout and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_shared_bus_ic;

    logic        inclk0 = 1'b0;
    logic        areset;
    always #5 inclk0 = ~inclk0;

    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
    logic        m0_we_i, m0_stb_i, m0_cyc_i, m0_ack_o, m0_err_o;
    logic        m1_we_i, m1_stb_i, m1_cyc_i, m1_ack_o, m1_err_o;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic [31:0] s0_adr_o, s0_dat_o, s0_dat_i, s1_adr_o, s1_dat_o, s1_dat_i;
    logic [31:0] s2_adr_o, s2_dat_o, s2_dat_i;
    logic        s0_we_o, s0_stb_o, s0_cyc_o, s1_we_o, s1_stb_o, s1_cyc_o;
    logic        s2_we_o, s2_stb_o, s2_cyc_o;
    logic [3:0]  s0_sel_o, s1_sel_o, s2_sel_o;

    // Behavioural slaves: ack lat[k]+1 cycles after stb rises; lat<0 = never.
    logic [2:0]  sack;
    int          wcnt[3];
    int          lat[3];
    logic [31:0] rdata[3];
    logic [2:0]  sstb;
    assign sstb     = {s2_stb_o, s1_stb_o, s0_stb_o};
    assign s0_dat_i = rdata[0];
    assign s1_dat_i = rdata[1];
    assign s2_dat_i = rdata[2];

    always @(posedge inclk0) begin
        for (int k = 0; k < 3; k++) begin
            if (areset || !sstb[k] || sack[k]) begin
                sack[k] <= 1'b0;
                wcnt[k] <= 0;
            end else if (lat[k] >= 0 && wcnt[k] >= lat[k]) begin
                sack[k] <= 1'b1;
            end else begin
                wcnt[k] <= wcnt[k] + 1;
            end
        end
    end

    int cycn = 0;
    always @(posedge inclk0) cycn <= cycn + 1;

    wb_shared_bus_ic #(.TIMEOUT(8)) dut (
        .inclk0(inclk0), .areset(areset),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s0_adr_o(s0_adr_o), .s0_dat_o(s0_dat_o), .s0_dat_i(s0_dat_i), .s0_we_o(s0_we_o),
        .s0_sel_o(s0_sel_o), .s0_stb_o(s0_stb_o), .s0_cyc_o(s0_cyc_o), .s0_ack_i(sack[0]),
        .s1_adr_o(s1_adr_o), .s1_dat_o(s1_dat_o), .s1_dat_i(s1_dat_i), .s1_we_o(s1_we_o),
        .s1_sel_o(s1_sel_o), .s1_stb_o(s1_stb_o), .s1_cyc_o(s1_cyc_o), .s1_ack_i(sack[1]),
        .s2_adr_o(s2_adr_o), .s2_dat_o(s2_dat_o), .s2_dat_i(s2_dat_i), .s2_we_o(s2_we_o),
        .s2_sel_o(s2_sel_o), .s2_stb_o(s2_stb_o), .s2_cyc_o(s2_cyc_o), .s2_ack_i(sack[2])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int m, input logic cyc, input logic we,
                         input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        if (m == 0) begin
            m0_cyc_i = cyc; m0_stb_i = cyc; m0_we_i = we; m0_sel_i = sel;
            m0_adr_i = adr; m0_dat_i = dat;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = cyc; m1_we_i = we; m1_sel_i = sel;
            m1_adr_i = adr; m1_dat_i = dat;
        end
    endtask

    function automatic logic get_ack(input int m);
        return (m == 0) ? m0_ack_o : m1_ack_o;
    endfunction
    function automatic logic get_err(input int m);
        return (m == 0) ? m0_err_o : m1_err_o;
    endfunction
    function automatic logic [31:0] get_rdat(input int m);
        return (m == 0) ? m0_dat_o : m1_dat_o;
    endfunction

    // Every control strobe the bus drives, packed so "all quiet" is one compare.
    function automatic logic [9:0] ctl_bits();
        return {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o,
                s0_stb_o, s0_cyc_o, s1_stb_o, s1_cyc_o, s2_stb_o, s2_cyc_o};
    endfunction

    task automatic set_default_lat();
        lat[0] = 0; lat[1] = 0; lat[2] = 1;
    endtask

    task automatic do_reset();
        @(posedge inclk0); #1;
        areset = 1'b1;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge inclk0);
        #1 areset = 1'b0;
    endtask

    typedef struct {
        int          m;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        int          slv;   // 3 = unmapped
        logic [31:0] rdat;
    } vec_t;

    vec_t vecs[10];

    task automatic run_txn(input vec_t v, input int idx);
        int acks = 0, errs = 0, oth = 0;
        logic [2:0] mask = 3'b000;
        logic [31:0] rd = 32'h0, cadr = 32'h0, cdat = 32'h0;
        logic [3:0] csel = 4'h0;
        logic cwe = 1'b0, done = 1'b0;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(posedge inclk0); #1;
        drive(v.m, 1'b1, v.we, v.sel, v.adr, v.dat);
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge inclk0);
            mask |= sstb;
            if (s0_stb_o) begin cadr = s0_adr_o; cdat = s0_dat_o; csel = s0_sel_o; cwe = s0_we_o; end
            if (s1_stb_o) begin cadr = s1_adr_o; cdat = s1_dat_o; csel = s1_sel_o; cwe = s1_we_o; end
            if (s2_stb_o) begin cadr = s2_adr_o; cdat = s2_dat_o; csel = s2_sel_o; cwe = s2_we_o; end
            if (get_ack(1 - v.m) || get_err(1 - v.m)) oth++;
            if (get_ack(v.m) && get_err(v.m)) oth++;
            if (get_ack(v.m)) begin acks++; rd = get_rdat(v.m); done = 1'b1; end
            if (get_err(v.m)) begin errs++; done = 1'b1; end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        @(posedge inclk0); #1;
        drive(v.m, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) begin
            @(negedge inclk0);
            mask |= sstb;
            if (get_ack(v.m)) acks++;
            if (get_err(v.m)) errs++;
            if (get_ack(1 - v.m) || get_err(1 - v.m)) oth++;
        end
        check({tag, "_acks"}, 32'(acks), (v.slv == 3) ? 32'd0 : 32'd1);
        check({tag, "_errs"}, 32'(errs), (v.slv == 3) ? 32'd1 : 32'd0);
        check({tag, "_stbmask"}, 32'(mask), (v.slv == 3) ? 32'd0 : (32'd1 << v.slv));
        check({tag, "_other"}, 32'(oth), 32'd0);
        if (v.slv != 3) begin
            check({tag, "_adr"}, cadr, v.adr);
            check({tag, "_we"}, 32'(cwe), 32'(v.we));
            check({tag, "_sel"}, 32'(csel), 32'(v.sel));
            if (v.we) check({tag, "_wdat"}, cdat, v.dat);
            else      check({tag, "_rdat"}, rd, v.rdat);
        end
    endtask

    // Both masters request in the same cycle; reports ack cycles and the
    // first cycle each slave was strobed.
    task automatic run_tie(output int t0, output int t1, output int ts0, output int ts1);
        t0 = -1; t1 = -1; ts0 = -1; ts1 = -1;
        @(posedge inclk0); #1;
        drive(0, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
        drive(1, 1'b1, 1'b0, 4'hF, 32'h1000_0000, 32'h0);
        for (int i = 0; i < 40 && (t0 < 0 || t1 < 0); i++) begin
            @(negedge inclk0);
            if (s0_stb_o && ts0 < 0) ts0 = cycn;
            if (s1_stb_o && ts1 < 0) ts1 = cycn;
            if (m0_ack_o && t0 < 0) t0 = cycn;
            if (m1_ack_o && t1 < 0) t1 = cycn;
            @(posedge inclk0); #1;
            if (t0 >= 0) drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            if (t1 >= 0) drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
        check("tie_both_done", 32'((t0 >= 0) && (t1 >= 0)), 32'd1);
        repeat (3) @(posedge inclk0);
    endtask

    initial begin
        int t0, t1, ts0, ts1, nstb, ncyc, nerr, nack, nother;
        rdata[0] = 32'hA0A0_0001;
        rdata[1] = 32'hB0B0_0002;
        rdata[2] = 32'h0000_0060;
        set_default_lat();
        //            m  we    sel      adr            dat            slv  rdat
        vecs[0] = '{1, 1'b0, 4'hF,  32'h8000_0014, 32'h0,         2, 32'h0000_0060};
        vecs[1] = '{0, 1'b0, 4'hF,  32'h0000_0100, 32'h0,         0, 32'hA0A0_0001};
        vecs[2] = '{1, 1'b1, 4'h3,  32'h1000_0004, 32'hDEAD_BEEF, 1, 32'h0};
        vecs[3] = '{1, 1'b0, 4'hF,  32'h4000_0000, 32'h0,         3, 32'h0};
        vecs[4] = '{0, 1'b0, 4'hF,  32'h0000_07FC, 32'h0,         0, 32'hA0A0_0001};
        vecs[5] = '{0, 1'b0, 4'hF,  32'h0000_0800, 32'h0,         3, 32'h0};
        vecs[6] = '{1, 1'b0, 4'hF,  32'h1000_FFFC, 32'h0,         1, 32'hB0B0_0002};
        vecs[7] = '{1, 1'b0, 4'hF,  32'h1001_0000, 32'h0,         3, 32'h0};
        vecs[8] = '{0, 1'b1, 4'h8,  32'h8000_001F, 32'h5500_0000, 2, 32'h0};
        vecs[9] = '{1, 1'b0, 4'hF,  32'h8000_0020, 32'h0,         3, 32'h0};

        areset = 1'b1;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(posedge inclk0);
        @(negedge inclk0);
        check("rst_ctl", 32'(ctl_bits()), 32'd0);
        #1 areset = 1'b0;
        @(negedge inclk0);
        check("idle_ctl", 32'(ctl_bits()), 32'd0);
        check("idle_sadr", s0_adr_o | s1_adr_o | s2_adr_o, 32'h0);
        check("idle_sdat", s0_dat_o | s1_dat_o | s2_dat_o, 32'h0);
        check("idle_swe_sel", 32'({s0_we_o, s1_we_o, s2_we_o, s0_sel_o, s1_sel_o, s2_sel_o}), 32'h0);
        check("idle_mdat", m0_dat_o | m1_dat_o, 32'h0);

        for (int i = 0; i < 10; i++) run_txn(vecs[i], i);

        // Tie from reset: m0 first, m1 strobed 3 cycles after m0's ack
        // (m0 drops next cycle, IDLE the cycle after, then one arbitration cycle).
        do_reset();
        run_tie(t0, t1, ts0, ts1);
        check("tie1_m0_first", 32'(t0 < t1), 32'd1);
        check("tie1_m1_gap", 32'(ts1 - t0), 32'd3);
        // m0 alone wins next, so the following tie goes to m1.
        run_txn(vecs[1], 10);
        run_tie(t0, t1, ts0, ts1);
        check("tie2_m1_first", 32'(t1 < t0), 32'd1);
        check("tie2_m0_gap", 32'(ts0 - t1), 32'd3);

        // RAM never acks: 8 strobe cycles then one error pulse.
        lat[1] = -1;
        nstb = 0; ncyc = 0; nerr = 0; nack = 0; nother = 0;
        @(posedge inclk0); #1;
        drive(1, 1'b1, 1'b0, 4'hF, 32'h1000_0000, 32'h0);
        repeat (16) begin
            @(negedge inclk0);
            if (s1_stb_o) nstb++;
            if (s1_cyc_o) ncyc++;
            if (m1_err_o) nerr++;
            if (m1_ack_o) nack++;
            if (s0_stb_o || s2_stb_o || m0_ack_o || m0_err_o) nother++;
        end
        check("to_stb_cycles", 32'(nstb), 32'd8);
        check("to_cyc_cycles", 32'(ncyc), 32'd8);
        check("to_err_pulses", 32'(nerr), 32'd1);
        check("to_acks", 32'(nack), 32'd0);
        check("to_other", 32'(nother), 32'd0);
        @(posedge inclk0); #1;
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge inclk0);
        lat[1] = 0;
        run_txn(vecs[6], 11);

        // Reset while m0 is stalled on the ROM.
        lat[0] = -1;
        @(posedge inclk0); #1;
        drive(0, 1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
        repeat (4) @(negedge inclk0);
        check("mid_s0_stb", 32'(s0_stb_o), 32'd1);
        @(posedge inclk0); #1 areset = 1'b1;
        @(posedge inclk0);
        @(negedge inclk0);
        check("mid_rst_ctl", 32'(ctl_bits()), 32'd0);
        #1;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        lat[0] = 0;
        @(posedge inclk0); #1 areset = 1'b0;
        nack = 0;
        repeat (6) begin
            @(negedge inclk0);
            if (ctl_bits() != 10'd0) nack++;
        end
        check("post_rst_quiet", 32'(nack), 32'd0);
        run_txn(vecs[0], 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/wb_shared_bus_ic.md
Name: wb_shared_bus_ic

Overview:
- Wishbone shared-bus interconnect that sits directly downstream of the CPU's two wishbone bridges (instruction master, data master).
- Arbitrates between the two masters and decodes the winner's address to one of three slaves: boot ROM, RAM, UART16550.
- Returns an error for unmapped addresses and for slaves that never acknowledge.
- Replaces the point-to-point ibus→ROM / dbus→UART wiring in cpu_top, so the CPU can fetch from RAM and load constants from ROM.

Parameters:
- S0_BASE, 32'h0000_0000, ROM base address
- S0_MASK, 32'hFFFF_F800, ROM decode mask (2 KiB)
- S1_BASE, 32'h1000_0000, RAM base address
- S1_MASK, 32'hFFFF_0000, RAM decode mask (64 KiB)
- S2_BASE, 32'h8000_0000, UART base address
- S2_MASK, 32'hFFFF_FFE0, UART decode mask (32 B)
- TIMEOUT, 255, cycles of stb without ack before the transfer is errored; range 2..65535

Ports:
- inclk0  input  1  bus clock
- areset  input  1  reset, synchronous, active-high
- mN_adr_i  input  32  master N address (N=0 ibus, N=1 dbus)
- mN_dat_i  input  32  master N write data
- mN_dat_o  output  32  master N read data
- mN_we_i  input  1  master N write enable
- mN_sel_i  input  4  master N byte selects
- mN_stb_i, mN_cyc_i  input  1 each  master N strobe / cycle
- mN_ack_o  output  1  master N acknowledge
- mN_err_o  output  1  master N error
- sK_adr_o  output  32  slave K address (K=0 ROM, 1 RAM, 2 UART)
- sK_dat_o  output  32  slave K write data
- sK_dat_i  input  32  slave K read data
- sK_we_o  output  1  slave K write enable
- sK_sel_o  output  4  slave K byte selects
- sK_stb_o, sK_cyc_o  output  1 each  slave K strobe / cycle
- sK_ack_i  input  1  slave K acknowledge

Behaviour:
- Reset (areset high at a posedge inclk0): state=IDLE, grant=none, last_grant=1 (so m0 wins the first tie), timeout counter=0.
  - Every ack, err, stb and cyc output is 0 during reset and in IDLE.
  - dat/adr/sel/we outputs to slaves: 0.
  - mN_dat_o: 0 when not granted.
- Reset mid-transfer: outputs are 0 from the cycle after the reset edge; the in-flight transfer is dropped with no ack or err.
- FSM states: IDLE, BUSY, ERR, WAITDROP.
- IDLE:
  - Sample the mN_cyc_i & mN_stb_i requests.
  - Single requester → grant it.
  - Both requesting → grant the master that is not last_grant (round-robin).
  - Registered grant: 1 cycle arbitration latency, then BUSY. last_grant updates on grant.
- Decode (combinational, granted master's address): hit K when (adr & SK_MASK) == SK_BASE. On overlap, the lowest K wins.
  - No hit on entering BUSY → go to ERR instead; no slave is strobed.
- BUSY:
  - Granted master's adr/dat/we/sel/stb/cyc route combinationally to the decoded slave only; other slaves see stb=cyc=0.
  - sK_ack_i and sK_dat_i route combinationally to the granted master's ack/dat_o; zero latency added beyond arbitration.
  - Counter increments each cycle while stb is high and ack is low. It clears on ack.
  - Counter reaching TIMEOUT-1 → force slave stb/cyc low next cycle, go to ERR.
  - Granted master drops cyc → IDLE next cycle, grant released.
  - The master may keep cyc high for back-to-back accesses. Address is re-decoded every cycle.
  - An unmapped address while in BUSY → ERR.
- ERR: mN_err_o=1 for exactly one cycle to the granted master; ack stays 0. Then WAITDROP.
- WAITDROP: hold grant, drive nothing to slaves, return to IDLE when the granted master's cyc is 0.
- Ungranted master: ack=err=0. It sees its stb stall until granted; there is no request buffering.
- mN_ack_o and mN_err_o are never both 1.
- Simultaneous slave ack and timeout expiry in the same cycle: the ack wins and the counter clears.

Decomposition:
- Shared package wb_ic_pkg:
  - state enum (IDLE/BUSY/ERR/WAITDROP)
  - slave index constants (SLV_ROM=0, SLV_RAM=1, SLV_UART=2, SLV_NONE=3)
  - default base/mask constants
- One sub-module: wb_ic_arbiter. It holds the 2-way round-robin grant register and last_grant, with inputs req[1:0] and release, and outputs grant_valid and grant_idx.
- Decode, muxing and the timeout counter stay in the top.

Test Plan:
- m1 reads 0x8000_0014, UART acks 2 cycles after stb with dat 0x0000_0060 → m1_ack_o one cycle, m1_dat_o=0x0000_0060, s0/s1 stb never high, m0 ack=0.
- m0 and m1 both raise cyc/stb in the same cycle after reset (ROM 0x0000_0100, RAM 0x1000_0000) → m0 served first, m1 granted in the cycle after m0 drops cyc; repeating the tie grants m1 first.
- m1 writes 0x1000_0004, sel=4'b0011, dat 0xDEAD_BEEF → s1_we_o=1, s1_sel_o=4'b0011, s1_dat_o=0xDEAD_BEEF; no other slave strobed.
- m1 accesses 0x4000_0000 → no slave strobed, m1_err_o=1 for exactly one cycle, ack never 1.
- TIMEOUT=8, RAM never acks → s1_stb_o high 8 cycles then low, m1_err_o pulses once, IDLE after m1 drops cyc.
- areset asserted while m0 is in BUSY mid-ROM-read → all ack/err/stb/cyc 0 the next cycle, no stale ack after reset release.
